// File: rtl/counter_priority_sched_pkg.sv
// Shared definitions for the counter-cell priority scheduler.
// Holds the increment op encodings, the per-cell pending-state enum, the
// controller state enum, the base octal address of cell 0 and the default
// number of counter cells.
package counter_priority_sched_pkg;

    localparam int unsigned DefaultNcell = 29;
    localparam logic [11:0] BaseAddr     = 12'o0024;
    // Cell 045 (INLINK) sits at index 045 - 024.
    localparam int unsigned InlinkIdx    = 17;

    typedef enum logic [1:0] {
        OpPinc  = 2'b00,
        OpMinc  = 2'b01,
        OpShinc = 2'b10,
        OpShanc = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        PendNone  = 2'b00,
        PendPlus  = 2'b01,
        PendMinus = 2'b10
    } pend_e;

    typedef enum logic {
        StIdle = 1'b0,
        StInc  = 1'b1
    } state_e;

    // Shift cells turn PLUS into SHANC and MINUS into SHINC.
    function automatic op_e grant_op(pend_e pend, logic is_shift);
        op_e op;
        if (is_shift) begin
            op = (pend == PendPlus) ? OpShanc : OpShinc;
        end else begin
            op = (pend == PendPlus) ? OpPinc : OpMinc;
        end
        return op;
    endfunction

endpackage

// File: rtl/counter_prio_enc.sv
// Lowest-index-first priority encoder.
// Ports:
//   req_i   : request vector, bit 0 has the highest priority
//   idx_o   : index of the lowest set bit (0 when none set)
//   valid_o : at least one bit of req_i is set
module counter_prio_enc #(
    parameter int unsigned Width = 29,
    localparam int unsigned IdxW = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0] req_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             valid_o
);

    always_comb begin
        idx_o = '0;
        // Scan from the top so the lowest set bit is written last.
        for (int i = Width - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IdxW'(i);
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/counter_priority_sched.sv
// Counter-cell increment scheduler.
// Each cell latches a pending PLUS or MINUS request; at the end of every
// memory cycle (T12A) the lowest-index pending cell is granted an increment
// cycle, during which INKL is high and GRANT_ADDR/GRANT_OP describe it.
// Ports:
//   CLOCK      : system clock, all state on its rising edge
//   rst        : synchronous active-high reset
//   T12A       : one-clock end-of-memory-cycle strobe
//   INHINC     : blocks issue of new grants while high
//   REQ_P      : plus-request pulses, bit i = cell 024+i
//   REQ_M      : minus-request pulses, same indexing
//   INKL       : high for the memory cycle executing an increment
//   GRANT_ADDR : octal address of the granted cell
//   GRANT_OP   : PINC/MINC/SHINC/SHANC of the granted cell
//   PEND_ANY   : any cell has a pending request
//   LOST_CNT   : saturating count of dropped duplicate requests
module counter_priority_sched
    import counter_priority_sched_pkg::*;
#(
    parameter int unsigned      NCELL      = DefaultNcell,
    parameter logic [NCELL-1:0] SHIFT_MASK = {{(NCELL - 1){1'b0}}, 1'b1} << InlinkIdx
) (
    input  logic             CLOCK,
    input  logic             rst,
    input  logic             T12A,
    input  logic             INHINC,
    input  logic [NCELL-1:0] REQ_P,
    input  logic [NCELL-1:0] REQ_M,
    output logic             INKL,
    output logic [11:0]      GRANT_ADDR,
    output logic [1:0]       GRANT_OP,
    output logic             PEND_ANY,
    output logic [3:0]       LOST_CNT
);

    localparam int unsigned IdxW = (NCELL > 1) ? $clog2(NCELL) : 1;

    pend_e            pend_q [NCELL];
    pend_e            pend_d [NCELL];
    logic [NCELL-1:0] pend_vec;
    state_e           state_q, state_d;
    logic [11:0]      addr_q, addr_d;
    op_e              op_q, op_d;
    logic [3:0]       lost_q, lost_d;
    logic [7:0]       drop_cnt;
    logic [7:0]       lost_sum;
    logic [IdxW-1:0]  sel_idx;
    logic             sel_valid;
    logic             issue;
    logic             grant_fire;
    pend_e            cur;

    always_comb begin
        for (int i = 0; i < NCELL; i++) begin
            pend_vec[i] = (pend_q[i] != PendNone);
        end
    end

    counter_prio_enc #(
        .Width (NCELL)
    ) u_enc (
        .req_i   (pend_vec),
        .idx_o   (sel_idx),
        .valid_o (sel_valid)
    );

    assign issue = T12A && !INHINC && sel_valid;

    // Controller: IDLE waits for an issue; INC runs until T12A and either
    // chains straight into the next grant or falls back to IDLE.
    always_comb begin
        state_d    = state_q;
        grant_fire = 1'b0;
        case (state_q)
            StIdle: begin
                if (issue) begin
                    grant_fire = 1'b1;
                    state_d    = StInc;
                end
            end
            StInc: begin
                if (T12A) begin
                    if (issue) begin
                        grant_fire = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        op_d   = op_q;
        if (grant_fire) begin
            addr_d = BaseAddr + 12'(sel_idx);
            op_d   = grant_op(pend_q[sel_idx], SHIFT_MASK[sel_idx]);
        end
    end

    // Pending update. The grant clear is applied first so a request landing
    // on the granting clock becomes a fresh pending state.
    always_comb begin
        drop_cnt = '0;
        cur      = PendNone;
        for (int i = 0; i < NCELL; i++) begin
            cur       = (grant_fire && (sel_idx == IdxW'(i))) ? PendNone : pend_q[i];
            pend_d[i] = cur;
            if (REQ_P[i] && !REQ_M[i]) begin
                case (cur)
                    PendNone:  pend_d[i] = PendPlus;
                    PendPlus:  drop_cnt  = drop_cnt + 8'd1;
                    PendMinus: pend_d[i] = PendNone;
                    default:   pend_d[i] = PendNone;
                endcase
            end else if (REQ_M[i] && !REQ_P[i]) begin
                case (cur)
                    PendNone:  pend_d[i] = PendMinus;
                    PendMinus: drop_cnt  = drop_cnt + 8'd1;
                    PendPlus:  pend_d[i] = PendNone;
                    default:   pend_d[i] = PendNone;
                endcase
            end
        end
    end

    assign lost_sum = {4'b0000, lost_q} + drop_cnt;
    assign lost_d   = (lost_sum > 8'd15) ? 4'd15 : lost_sum[3:0];

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            for (int i = 0; i < NCELL; i++) begin
                pend_q[i] <= PendNone;
            end
            state_q <= StIdle;
            addr_q  <= '0;
            op_q    <= OpPinc;
            lost_q  <= '0;
        end else begin
            for (int i = 0; i < NCELL; i++) begin
                pend_q[i] <= pend_d[i];
            end
            state_q <= state_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            lost_q  <= lost_d;
        end
    end

    assign INKL       = (state_q == StInc);
    assign GRANT_ADDR = addr_q;
    assign GRANT_OP   = op_q;
    assign PEND_ANY   = |pend_vec;
    assign LOST_CNT   = lost_q;

endmodule

// File: tb/tb_counter_priority_sched.sv
module tb_counter_priority_sched;

    localparam int NC    = 29;
    localparam int SHIDX = 'o45 - 'o24;

    logic          CLOCK;
    logic          rst;
    logic          T12A;
    logic          INHINC;
    logic [NC-1:0] REQ_P;
    logic [NC-1:0] REQ_M;
    logic          INKL;
    logic [11:0]   GRANT_ADDR;
    logic [1:0]    GRANT_OP;
    logic          PEND_ANY;
    logic [3:0]    LOST_CNT;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 = none, 1 = plus, 2 = minus.
    int          mp [NC];
    logic        m_inkl;
    logic [11:0] m_addr;
    logic [1:0]  m_op;
    int          m_lost;

    counter_priority_sched dut (
        .CLOCK      (CLOCK),
        .rst        (rst),
        .T12A       (T12A),
        .INHINC     (INHINC),
        .REQ_P      (REQ_P),
        .REQ_M      (REQ_M),
        .INKL       (INKL),
        .GRANT_ADDR (GRANT_ADDR),
        .GRANT_OP   (GRANT_OP),
        .PEND_ANY   (PEND_ANY),
        .LOST_CNT   (LOST_CNT)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_any();
        logic a;
        a = 1'b0;
        for (int i = 0; i < NC; i++) if (mp[i] != 0) a = 1'b1;
        return a;
    endfunction

    // Applies the rules to the inputs present at this rising edge.
    task automatic model_step();
        int low;
        int drops;
        int want;
        if (rst) begin
            for (int i = 0; i < NC; i++) mp[i] = 0;
            m_inkl = 1'b0;
            m_addr = 12'd0;
            m_op   = 2'd0;
            m_lost = 0;
            return;
        end
        low = -1;
        for (int i = 0; i < NC; i++) if (mp[i] != 0 && low < 0) low = i;
        if (T12A && !INHINC && low >= 0) begin
            m_addr = 12'(20 + low);
            if (low == SHIDX) m_op = (mp[low] == 1) ? 2'b11 : 2'b10;
            else              m_op = (mp[low] == 1) ? 2'b00 : 2'b01;
            mp[low] = 0;
            m_inkl  = 1'b1;
        end else if (T12A) begin
            m_inkl = 1'b0;
        end
        drops = 0;
        for (int i = 0; i < NC; i++) begin
            if (REQ_P[i] != REQ_M[i]) begin
                want = REQ_P[i] ? 1 : 2;
                if (mp[i] == 0)         mp[i] = want;
                else if (mp[i] == want) drops++;
                else                    mp[i] = 0;
            end
        end
        m_lost = (m_lost + drops > 15) ? 15 : m_lost + drops;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge CLOCK) begin
        chk("inkl", 32'(INKL), 32'(m_inkl));
        chk("grant_addr", 32'(GRANT_ADDR), 32'(m_addr));
        chk("grant_op", 32'(GRANT_OP), 32'(m_op));
        chk("pend_any", 32'(PEND_ANY), 32'(model_any()));
        chk("lost_cnt", 32'(LOST_CNT), 32'(m_lost));
    end

    task automatic step(input logic r, input logic [NC-1:0] p, input logic [NC-1:0] m,
                        input logic t, input logic inh);
        rst    = r;
        REQ_P  = p;
        REQ_M  = m;
        T12A   = t;
        INHINC = inh;
        @(posedge CLOCK);
        model_step();
        @(negedge CLOCK);
    endtask

    function automatic logic [NC-1:0] bit_at(input int i);
        logic [NC-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    logic [31:0] r1, r2;
    logic        inh_r;

    initial begin
        for (int i = 0; i < NC; i++) mp[i] = 0;
        m_inkl = 1'b0;
        m_addr = '0;
        m_op   = '0;
        m_lost = 0;

        step(1'b1, '0, '0, 1'b0, 1'b0);
        step(1'b1, '0, '0, 1'b1, 1'b0);
        chk("reset_inkl", 32'(INKL), 32'd0);
        chk("reset_addr", 32'(GRANT_ADDR), 32'd0);
        chk("reset_op", 32'(GRANT_OP), 32'd0);
        chk("reset_lost", 32'(LOST_CNT), 32'd0);
        chk("reset_pend", 32'(PEND_ANY), 32'd0);

        // Single PINC on cell 0024.
        step(1'b0, bit_at(0), '0, 1'b0, 1'b0);
        chk("t36_pend", 32'(PEND_ANY), 32'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("t36_inkl", 32'(INKL), 32'd1);
        chk("t36_addr", 32'(GRANT_ADDR), 32'o0024);
        chk("t36_op", 32'(GRANT_OP), 32'd0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("t36_hold", 32'(INKL), 32'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("t36_end", 32'(INKL), 32'd0);
        chk("t36_addr_hold", 32'(GRANT_ADDR), 32'o0024);

        // Priority and back-to-back.
        step(1'b0, bit_at(5), bit_at(3), 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("t37_addr1", 32'(GRANT_ADDR), 32'o0027);
        chk("t37_op1", 32'(GRANT_OP), 32'd1);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("t37_inkl2", 32'(INKL), 32'd1);
        chk("t37_addr2", 32'(GRANT_ADDR), 32'o0031);
        chk("t37_op2", 32'(GRANT_OP), 32'd0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("t37_end", 32'(INKL), 32'd0);

        // Net-zero cancellation.
        step(1'b0, bit_at(2), '0, 1'b0, 1'b0);
        step(1'b0, '0, bit_at(2), 1'b0, 1'b0);
        chk("t38_pend", 32'(PEND_ANY), 32'd0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("t38_inkl", 32'(INKL), 32'd0);

        // Duplicate drops with saturation.
        for (int k = 0; k < 20; k++) step(1'b0, bit_at(7), '0, 1'b0, 1'b1);
        chk("t39_lost", 32'(LOST_CNT), 32'd15);
        chk("t39_pend", 32'(PEND_ANY), 32'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("t39_inkl", 32'(INKL), 32'd1);
        chk("t39_addr", 32'(GRANT_ADDR), 32'o0033);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("t39_one_grant", 32'(INKL), 32'd0);
        chk("t39_pend_clr", 32'(PEND_ANY), 32'd0);

        // Shift cell: request on the granting clock is retained.
        step(1'b0, bit_at(SHIDX), '0, 1'b0, 1'b0);
        step(1'b0, '0, bit_at(SHIDX), 1'b1, 1'b0);
        chk("t40_addr", 32'(GRANT_ADDR), 32'o0045);
        chk("t40_op1", 32'(GRANT_OP), 32'd3);
        chk("t40_pend", 32'(PEND_ANY), 32'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("t40_inkl2", 32'(INKL), 32'd1);
        chk("t40_op2", 32'(GRANT_OP), 32'd2);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("t40_end", 32'(INKL), 32'd0);

        // INHINC raised during INC only blocks the following grant.
        step(1'b0, bit_at(1) | bit_at(6), '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("inh_keep", 32'(INKL), 32'd1);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        chk("inh_block", 32'(INKL), 32'd0);
        chk("inh_pend", 32'(PEND_ANY), 32'd1);

        // Reset mid-INC with three cells pending.
        step(1'b1, '0, '0, 1'b0, 1'b0);
        step(1'b0, bit_at(4) | bit_at(9) | bit_at(10) | bit_at(12), '0, 1'b0, 1'b0);
        step(1'b0, bit_at(9), '0, 1'b1, 1'b0);
        chk("t41_inc", 32'(INKL), 32'd1);
        chk("t41_lost_pre", 32'(LOST_CNT), 32'd1);
        step(1'b1, bit_at(20), '0, 1'b1, 1'b0);
        chk("t41_inkl", 32'(INKL), 32'd0);
        chk("t41_pend", 32'(PEND_ANY), 32'd0);
        chk("t41_lost", 32'(LOST_CNT), 32'd0);

        // Randomized traffic.
        inh_r = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            r1 = $urandom & $urandom & $urandom & $urandom;
            r2 = $urandom & $urandom & $urandom & $urandom;
            if ($urandom_range(0, 24) == 0) inh_r = ~inh_r;
            step(($urandom_range(0, 399) == 0), r1[NC-1:0], r2[NC-1:0],
                 ($urandom_range(0, 2) == 0), inh_r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_priority_sched.md
COUNTER_PRIORITY_SCHED -- requirements
Module: counter_priority_sched

Interface
REQ-001 Parameter NCELL, default 29, is the number of counter cells, octal addresses 024..060.
REQ-002 Parameter SHIFT_MASK, default bit for cell 045 (INLINK) set, marks shift-type cells.
REQ-003 Port CLOCK  input  1  system clock; the only clock, all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port T12A  input  1  one-clock strobe marking the end of each memory cycle.
REQ-006 Port INHINC  input  1  level; when high, no new grant issues.
REQ-007 Port REQ_P  input  NCELL  one-clock plus-request pulses, bit i = cell 024+i.
REQ-008 Port REQ_M  input  NCELL  one-clock minus-request pulses, same indexing.
REQ-009 Port INKL  output  1  high for the whole memory cycle in which a counter increment executes.
REQ-010 Port GRANT_ADDR  output  12  octal address of the granted cell, valid while INKL is high.
REQ-011 Port GRANT_OP  output  2  00 PINC, 01 MINC, 10 SHINC, 11 SHANC; valid while INKL is high.
REQ-012 Port PEND_ANY  output  1  one or more cells have a pending request.
REQ-013 Port LOST_CNT  output  4  saturating count of dropped duplicate requests.

Function
REQ-014 Pending state per cell is one of NONE, PLUS or MINUS.
REQ-015 REQ_P on NONE gives PLUS; REQ_M on NONE gives MINUS.
REQ-016 An opposite-polarity request on a pending cell returns it to NONE (net zero).
REQ-017 REQ_P and REQ_M on the same cell in the same clock leave its state unchanged.
REQ-018 A same-polarity request on a pending cell is dropped and increments LOST_CNT, which saturates at 15.
REQ-019 Controller states: IDLE and INC.
REQ-020 At T12A with INHINC low and PEND_ANY high, the lowest-index pending cell is selected.
REQ-021 The selected cell's address and op are registered, its pending state is cleared and the state becomes INC.
REQ-022 INKL rises on the clock after that T12A.
REQ-023 In INC, the next T12A ends the cycle.
REQ-024 At that T12A a new grant issues in the same clock (back-to-back) if the issue conditions hold; otherwise the state returns to IDLE and INKL falls.
REQ-025 At most one grant is issued per memory cycle.
REQ-026 Op mapping for non-shift cells: PLUS gives PINC, MINUS gives MINC.
REQ-027 Op mapping for SHIFT_MASK cells: PLUS gives SHANC, MINUS gives SHINC.
REQ-028 A request arriving on the T12A clock that grants the same cell is retained as a new pending state; the request is applied after the grant clear.
REQ-029 INHINC rising during INC does not abort the current cycle; it only blocks the next grant.
REQ-030 GRANT_ADDR and GRANT_OP hold their last values while INKL is low.
REQ-031 PEND_ANY is combinational OR over the pending states.

Reset
REQ-032 When rst is high at a clock edge: all pending states go to NONE, state goes to IDLE, INKL=0, GRANT_ADDR=0, GRANT_OP=00, LOST_CNT=0.
REQ-033 Reset applies mid-INC: the current grant is abandoned, INKL=0 on the next clock, and requests in that clock are ignored.

Structure
REQ-034 A shared package holds the op encodings (PINC/MINC/SHINC/SHANC), the pending-state enum, the base address 12'o0024 and the default NCELL.
REQ-035 A single sub-module, counter_prio_enc, implements the NCELL-wide lowest-index priority encoder with a valid output.

Verification
REQ-036 REQ_P[0] pulse, then T12A -> next clock INKL=1, GRANT_ADDR=0024, GRANT_OP=00; INKL=0 after the following T12A.
REQ-037 REQ_P[5] and REQ_M[3] pending at T12A -> cell 0027 granted MINC first, cell 0031 PINC in the next cycle with INKL held high.
REQ-038 REQ_P[2] then REQ_M[2] before T12A -> PEND_ANY=0, no grant at T12A.
REQ-039 Twenty REQ_P[7] pulses with INHINC=1 -> LOST_CNT=15, one pending PLUS; INHINC=0 then T12A -> exactly one grant, address 0033.
REQ-040 Shift cell 045 REQ_M at T12A while that cell is granted SHANC -> the grant completes and SHINC issues in the following cycle.
REQ-041 rst asserted during INC with three cells pending -> INKL=0, PEND_ANY=0, LOST_CNT=0 one clock later.
